wb_bram_arbiter: RTL
====================

Name: wb_bram_arbiter

Overview:
Two-requester Wishbone (pipelined, single outstanding) arbiter that shares one port of the true dual-port block RAM between two masters. It drives the RAM port's enable, write-enable, address and data, and returns read data with a fixed latency. It arbitrates round-robin. Optionally, it zero-fills the whole RAM after reset before accepting any traffic.

Parameters:
DATA_WIDTH, 32, word width; must match the RAM.
ADDR_WIDTH, 10, word address width; must match the RAM.
MEM_DEPTH, (1 << ADDR_WIDTH), number of words cleared by the init sweep; must be <= 2^ADDR_WIDTH.
CLEAR_ON_RESET, 1, 1 = zero-fill RAM after reset; 0 = go straight to IDLE.

Ports:
i_clk  in  1  single clock for arbiter and shared RAM port
i_reset  in  1  asynchronous, active-high reset
i_cyc0  in  1  requester 0 bus cycle
i_stb0  in  1  requester 0 strobe
i_we0  in  1  requester 0 write (1) / read (0)
i_addr0  in  ADDR_WIDTH  requester 0 word address
i_data0  in  DATA_WIDTH  requester 0 write data
o_stall0  out  1  requester 0 stall (combinational)
o_ack0  out  1  requester 0 acknowledge, one-cycle pulse
o_data0  out  DATA_WIDTH  requester 0 read data, valid with o_ack0
i_cyc1, i_stb1, i_we1, i_addr1, i_data1, o_stall1, o_ack1, o_data1  same as requester 0, for requester 1
o_bram_en  out  1  RAM port enable
o_bram_we  out  1  RAM port write enable
o_bram_addr  out  ADDR_WIDTH  RAM port address
o_bram_din  out  DATA_WIDTH  RAM port write data
i_bram_dout  in  DATA_WIDTH  RAM port read data (registered in RAM, one-clock latency)
o_init_busy  out  1  high while the zero-fill sweep is running

Behaviour:
- Reset (async assert, sync release):
  - State = INIT if CLEAR_ON_RESET, else IDLE.
  - Sweep counter = 0, last_grant = 1.
  - o_ack*, o_data*, o_bram_en, o_bram_we, o_bram_addr, o_bram_din = 0.
- States: INIT, IDLE, CMD, RESP.
- INIT:
  - Each cycle: o_bram_en=1, o_bram_we=1, o_bram_din=0, o_bram_addr=counter; counter increments.
  - After the write at address MEM_DEPTH-1 is issued, go to IDLE.
  - o_init_busy=1 and o_stall0=o_stall1=1 throughout INIT.
  - Reset mid-sweep restarts at address 0.
- Request: reqN = i_cycN && i_stbN.
- Grant, combinational in IDLE only:
  - If exactly one reqN, grant it.
  - If both, grant the requester != last_grant; requester 0 wins the first tie after reset.
- Stall: o_stallN = (state != IDLE) || !grantN. A request is accepted at an edge where reqN && !o_stallN.
- On acceptance at edge k:
  - Latch owner, we, addr, data.
  - Update last_grant = owner.
  - Drive o_bram_en=1, o_bram_we=we, o_bram_addr, o_bram_din for exactly one cycle (state CMD).
- CMD: the RAM samples at edge k+1; o_bram_en returns to 0; go to RESP.
- RESP:
  - At edge k+2, o_ackOWNER=1 for one cycle and o_dataOWNER=i_bram_dout.
  - For a write, o_data is updated with the pre-write read value; masters ignore it.
  - Go to IDLE.
- Latency and throughput:
  - Ack is always exactly 2 clocks after acceptance.
  - Max throughput is 1 access per 3 clocks.
  - A new request can be accepted in the same cycle ack is high.
- Abort: if the owner's i_cyc drops during CMD/RESP, the RAM access still completes (writes are not undone) but o_ack is suppressed. The FSM returns to IDLE normally.
- Non-owner ack and non-owner o_data never change.
- i_stb without i_cyc is ignored.
- Never more than one o_bram_en cycle per accepted request. o_bram_en=0 in IDLE when nothing is accepted.

Test Plan:
- Reset with CLEAR_ON_RESET=1, MEM_DEPTH=16 -> o_init_busy high for 16 cycles; addresses 0..15 each written once with 0; both stalls high; then IDLE, o_init_busy=0.
- Requester 0 writes 0xDEADBEEF to addr 0x005, then reads addr 0x005 -> each ack exactly 2 clocks after its acceptance; o_data0=0xDEADBEEF.
- Both request in the same cycle, repeatedly (r0 addr 0x010, r1 addr 0x020) -> grants alternate 0,1,0,1; each ack goes only to its owner.
- Requester 1 accepted, i_cyc1 dropped in CMD -> no o_ack1; RAM write at its address still observed; next request accepted normally.
- Async reset asserted mid-sweep at counter=7 -> outputs zero immediately; sweep restarts at address 0 after release.
- CLEAR_ON_RESET=0 -> requester accepted in the first cycle after reset release; o_init_busy never high.

Source files
------------

// File: rtl/wb_bram_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between two pipelined Wishbone masters.
// One outstanding access at a time; ack lands two clocks after acceptance. Optional zero-fill sweep after reset.
module wb_bram_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int MEM_DEPTH      = (1 << ADDR_WIDTH),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cyc0,
  input  logic                  i_stb0,
  input  logic                  i_we0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_data0,
  output logic                  o_stall0,
  output logic                  o_ack0,
  output logic [DATA_WIDTH-1:0] o_data0,
  input  logic                  i_cyc1,
  input  logic                  i_stb1,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic                  o_stall1,
  output logic                  o_ack1,
  output logic [DATA_WIDTH-1:0] o_data1,
  output logic                  o_bram_en,
  output logic                  o_bram_we,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0] o_bram_din,
  input  logic [DATA_WIDTH-1:0] i_bram_dout,
  output logic                  o_init_busy
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CMD, S_RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_t                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_counter;
  logic                    r_last_grant;
  logic                    r_owner;
  logic                    r_abort;
  logic                    r_bram_en, r_bram_we;
  logic [ADDR_WIDTH-1:0]   r_bram_addr;
  logic [DATA_WIDTH-1:0]   r_bram_din;
  logic                    r_ack0, r_ack1;
  logic [DATA_WIDTH-1:0]   r_data0, r_data1;

  logic w_req0, w_req1, w_grant0, w_grant1, w_accept, w_owner_cyc;

  assign w_req0      = i_cyc0 && i_stb0;
  assign w_req1      = i_cyc1 && i_stb1;
  assign w_accept    = w_grant0 || w_grant1;
  assign w_owner_cyc = r_owner ? i_cyc1 : i_cyc0;

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      if (CLEAR_ON_RESET) r_state <= S_INIT;
      else                r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT: if (r_counter == LAST_ADDR) w_next = S_IDLE;
      S_IDLE: if (w_accept) w_next = S_CMD;
      S_CMD:  w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Tie goes to the requester that did not win last time.
  always_comb begin
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    o_init_busy = (r_state == S_INIT);
    if (r_state == S_IDLE) begin
      w_grant0 = w_req0 && (!w_req1 || r_last_grant);
      w_grant1 = w_req1 && (!w_req0 || !r_last_grant);
    end
    o_stall0 = !w_grant0;
    o_stall1 = !w_grant1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_counter    <= '0;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_abort      <= 1'b0;
      r_bram_en    <= 1'b0;
      r_bram_we    <= 1'b0;
      r_bram_addr  <= '0;
      r_bram_din   <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_data0      <= '0;
      r_data1      <= '0;
    end else begin
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_bram_en <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_bram_en   <= 1'b1;
          r_bram_we   <= 1'b1;
          r_bram_addr <= r_counter;
          r_bram_din  <= '0;
          r_counter   <= r_counter + 1'b1;
        end
        S_IDLE: begin
          if (w_accept) begin
            r_owner      <= w_grant1;
            r_last_grant <= w_grant1;
            r_abort      <= 1'b0;
            r_bram_en    <= 1'b1;
            r_bram_we    <= w_grant1 ? i_we1   : i_we0;
            r_bram_addr  <= w_grant1 ? i_addr1 : i_addr0;
            r_bram_din   <= w_grant1 ? i_data1 : i_data0;
          end
        end
        S_CMD: begin
          if (!w_owner_cyc) r_abort <= 1'b1;
        end
        S_RESP: begin
          // Dropping cyc anywhere after acceptance suppresses the ack; the RAM access already happened.
          if (r_owner) begin
            r_data1 <= i_bram_dout;
            r_ack1  <= !r_abort && i_cyc1;
          end else begin
            r_data0 <= i_bram_dout;
            r_ack0  <= !r_abort && i_cyc0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_bram_en   = r_bram_en;
  assign o_bram_we   = r_bram_we;
  assign o_bram_addr = r_bram_addr;
  assign o_bram_din  = r_bram_din;
  assign o_ack0      = r_ack0;
  assign o_ack1      = r_ack1;
  assign o_data0     = r_data0;
  assign o_data1     = r_data1;

endmodule
